// File: rtl/instr_decode_stage_pkg.sv
// rtl/instr_decode_stage_pkg.sv - shared types, opcodes and FSM encoding for the decode stage
package instr_decode_stage_pkg;

    // Immediate class handed to the immediate generator; 3'b111 is never produced
    typedef enum logic [2:0] {
        IMM_R   = 3'b000,
        IMM_I   = 3'b001,
        IMM_S   = 3'b010,
        IMM_B   = 3'b011,
        IMM_U   = 3'b100,
        IMM_J   = 3'b101,
        IMM_CSR = 3'b110
    } imm_type_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // funct3 under SYSTEM: 000 is ECALL/EBREAK class, 100 is reserved
    localparam logic [2:0] F3_PRIV     = 3'b000;
    localparam logic [2:0] F3_RESERVED = 3'b100;

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fsm_state_e;

    // One buffered instruction with its decode captured at accept time
    typedef struct packed {
        logic [31:0] pc;
        logic [24:0] instr;
        imm_type_e   imm_type;
        logic        illegal;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{pc: 32'd0, instr: 25'd0, imm_type: IMM_R, illegal: 1'b0};

endpackage

// File: rtl/instr_decode_stage_if.sv
// rtl/instr_decode_stage_if.sv - fetch-side and decode-side handshake bundle
interface instr_decode_stage_if;

    logic        flush;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [24:0] id_instr;
    logic [2:0]  id_imm_type;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_illegal;

    // Seen from the decode stage
    modport slave (
        input  flush,
        input  if_valid, if_instr, if_pc,
        output if_ready,
        input  id_ready,
        output id_valid, id_pc, id_instr, id_imm_type,
        output id_rs1, id_rs2, id_rd, id_illegal
    );

    // Seen from the fetch unit / downstream consumer / bench
    modport master (
        output flush,
        output if_valid, if_instr, if_pc,
        input  if_ready,
        output id_ready,
        input  id_valid, id_pc, id_instr, id_imm_type,
        input  id_rs1, id_rs2, id_rd, id_illegal
    );

endinterface

// File: rtl/instr_decode_stage_imm_type_decoder.sv
// rtl/instr_decode_stage_imm_type_decoder.sv - combinational opcode to immediate-class decoder
module imm_type_decoder
    import instr_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output imm_type_e   imm_type,
    output logic        illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Only opcode and funct3 steer the class; the rest of the word is carried elsewhere
    assign unused_bits = ^{instr[31:15], instr[11:7]};

    // Map opcode (and funct3 for SYSTEM) onto an immediate class; unknowns fall to R + illegal
    always_comb begin
        imm_type = IMM_R;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP:       imm_type = IMM_R;
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_JALR,
            OPC_MISC_MEM: imm_type = IMM_I;
            OPC_STORE:    imm_type = IMM_S;
            OPC_BRANCH:   imm_type = IMM_B;
            OPC_LUI,
            OPC_AUIPC:    imm_type = IMM_U;
            OPC_JAL:      imm_type = IMM_J;
            OPC_SYSTEM: begin
                if (funct3 == F3_PRIV) begin
                    imm_type = IMM_I;
                end else if (funct3 == F3_RESERVED) begin
                    imm_type = IMM_R;
                    illegal  = 1'b1;
                end else begin
                    imm_type = IMM_CSR;
                end
            end
            default: begin
                imm_type = IMM_R;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - two-entry skid buffer that decodes instructions at accept time
module instr_decode_stage
    import instr_decode_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    instr_decode_stage_if.slave   bus
);

    fsm_state_e state;
    entry_t     head;
    entry_t     tail;
    logic       if_ready_q;
    logic       id_valid_q;

    imm_type_e  dec_type;
    logic       dec_illegal;
    entry_t     incoming;
    logic       accept;
    logic       issue;

    // Single decoder sits on the fetch side so each entry carries its decode with it
    imm_type_decoder u_imm_type_decoder (
        .instr    (bus.if_instr),
        .imm_type (dec_type),
        .illegal  (dec_illegal)
    );

    assign incoming = '{pc: bus.if_pc, instr: bus.if_instr[31:7], imm_type: dec_type, illegal: dec_illegal};

    // Both handshakes use registered readiness/validity, so neither side sees a combinational path
    assign accept = bus.if_valid & if_ready_q;
    assign issue  = id_valid_q & bus.id_ready;

    // Occupancy FSM with registered if_ready/id_valid; head always holds the oldest entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            head       <= ENTRY_RESET;
            tail       <= ENTRY_RESET;
            if_ready_q <= 1'b1;
            id_valid_q <= 1'b0;
        end else if (bus.flush) begin
            // Redirect wins: drop everything, including a beat arriving this cycle
            state      <= ST_EMPTY;
            if_ready_q <= 1'b1;
            id_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head       <= incoming;
                        state      <= ST_ONE;
                        id_valid_q <= 1'b1;
                        if_ready_q <= 1'b1;
                    end
                end
                ST_ONE: begin
                    case ({accept, issue})
                        2'b10: begin
                            tail       <= incoming;
                            state      <= ST_FULL;
                            if_ready_q <= 1'b0;
                        end
                        2'b01: begin
                            state      <= ST_EMPTY;
                            id_valid_q <= 1'b0;
                        end
                        2'b11: begin
                            // Old head leaves while the new beat takes its place
                            head <= incoming;
                        end
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    if (issue) begin
                        head       <= tail;
                        state      <= ST_ONE;
                        if_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    if_ready_q <= 1'b1;
                    id_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ready    = if_ready_q;
    assign bus.id_valid    = id_valid_q;
    assign bus.id_pc       = head.pc;
    assign bus.id_instr    = head.instr;
    assign bus.id_imm_type = head.imm_type;
    assign bus.id_illegal  = head.illegal;

    // Stored word starts at instr bit 7, so register fields shift down by 7
    assign bus.id_rs1 = head.instr[12:8];
    assign bus.id_rs2 = head.instr[17:13];
    assign bus.id_rd  = head.instr[4:0];

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage
module tb_instr_decode_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    instr_decode_stage_if bus ();

    instr_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [2:0]  t;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference classification written straight from the opcode table
    function automatic void ref_decode(input logic [31:0] w, output logic [2:0] t, output logic ill);
        logic [6:0] op;
        logic [2:0] f3;
        op  = w[6:0];
        f3  = w[14:12];
        t   = 3'd0;
        ill = 1'b0;
        if (op == 7'h33)                                            t = 3'd0;
        else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h0F) t = 3'd1;
        else if (op == 7'h23)                                       t = 3'd2;
        else if (op == 7'h63)                                       t = 3'd3;
        else if (op == 7'h37 || op == 7'h17)                        t = 3'd4;
        else if (op == 7'h6F)                                       t = 3'd5;
        else if (op == 7'h73 && f3 == 3'd0)                         t = 3'd1;
        else if (op == 7'h73 && f3 != 3'd4)                         t = 3'd6;
        else                                                        ill = 1'b1;
    endfunction

    // One cycle of stimulus; an accepted beat becomes expected once the edge has taken it
    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy, input logic fl, output logic acc);
        exp_t e;
        @(negedge clk);
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.id_ready = rdy;
        bus.flush    = fl;
        acc = v && bus.if_ready && !fl;
        @(posedge clk);
        #1;
        if (acc) begin
            e.pc    = pc;
            e.instr = instr;
            ref_decode(instr, e.t, e.ill);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        drive(1'b0, 32'h0, 32'h0, rdy, 1'b0, acc);
    endtask

    // Monitor: compare head against the oldest expected beat whenever the stage presents one
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("if_ready", 80'(bus.if_ready), 80'(exp_q.size() < 2));
                check("id_valid", 80'(bus.id_valid), 80'(exp_q.size() != 0));
                if (bus.id_valid && exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("head_entry",
                          80'({bus.id_pc, bus.id_instr, bus.id_imm_type, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_illegal}),
                          80'({e.pc, e.instr[31:7], e.t, e.instr[19:15], e.instr[24:20], e.instr[11:7], e.ill}));
                    if (bus.id_ready) void'(exp_q.pop_front());
                end
                if (bus.flush) exp_q.delete();
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_if_ready"}, 80'(bus.if_ready), 80'(1));
        check({tag, "_id_valid"}, 80'(bus.id_valid), 80'(0));
        check({tag, "_id_fields"},
              80'({bus.id_pc, bus.id_instr, bus.id_imm_type, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_illegal}),
              80'(0));
    endtask

    int unsigned opc_tab[14] = '{32'h33, 32'h13, 32'h03, 32'h67, 32'h0F, 32'h23, 32'h63,
                                 32'h37, 32'h17, 32'h6F, 32'h73, 32'h73, 32'h7F, 32'h0B};

    initial begin
        logic        acc;
        logic [31:0] w;
        logic [31:0] pc;
        int          guard;

        bus.if_valid = 1'b0;
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        bus.id_ready = 1'b0;
        bus.flush    = 1'b0;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // addi x1, x0, 5 through an empty stage
        drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, acc);
        check("addi_accepted", 80'(acc), 80'(1));
        idle(1'b1);

        // Three back-to-back beats against a stalled consumer
        drive(1'b1, 32'h00000463, 32'h200, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h000000EF, 32'h204, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h123450B7, 32'h208, 1'b0, 1'b0, acc);
        check("third_beat_blocked", 80'(acc), 80'(0));
        guard = 0;
        do begin
            drive(1'b1, 32'h123450B7, 32'h208, 1'b1, 1'b0, acc);
            guard++;
        end while (!acc && guard < 10);
        check("third_beat_eventually", 80'(acc), 80'(1));
        repeat (3) idle(1'b1);

        // Ten beats streaming with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h00100013 + (i << 7), 32'h300 + i * 4, 1'b1, 1'b0, acc);
            check("stream_accept", 80'(acc), 80'(1));
        end
        idle(1'b1);

        // Flush while full, with a beat offered in the flush cycle
        drive(1'b1, 32'h00208033, 32'h400, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h00310093, 32'h404, 1'b0, 1'b0, acc);
        drive(1'b1, 32'hDEADB0B7, 32'h408, 1'b0, 1'b1, acc);
        idle(1'b1);
        idle(1'b1);

        // CSR class and an illegal opcode
        drive(1'b1, 32'h30529073, 32'h500, 1'b1, 1'b0, acc);
        drive(1'b1, 32'h0000007F, 32'h504, 1'b1, 1'b0, acc);
        drive(1'b1, 32'h00004073, 32'h508, 1'b1, 1'b0, acc);
        idle(1'b1);

        // Asynchronous reset while full
        drive(1'b1, 32'h00000463, 32'h600, 1'b0, 1'b0, acc);
        drive(1'b1, 32'h000000EF, 32'h604, 1'b0, 1'b0, acc);
        @(negedge clk);
        bus.if_valid = 1'b0;
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        idle(1'b1);

        // Randomized traffic
        pc = 32'h1000;
        for (int i = 0; i < 500; i++) begin
            w = $urandom;
            w[6:0] = opc_tab[$urandom_range(13)][6:0];
            drive(($urandom_range(3) != 0), w, pc, ($urandom_range(2) != 0),
                  ($urandom_range(24) == 0), acc);
            if (acc) pc = pc + 4;
        end

        repeat (4) idle(1'b1);
        check("drained", 80'(exp_q.size()), 80'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RST_N  input  1  asynchronous, active-low reset.
REQ-003 FLUSH  input  1  discard all buffered instructions (branch/trap redirect).
REQ-004 IF_VALID  input  1  fetch presents an instruction this cycle.
REQ-005 IF_READY  output  1  stage accepts an instruction this cycle.
REQ-006 IF_INSTR  input  32  fetched instruction word.
REQ-007 IF_PC  input  32  PC of IF_INSTR.
REQ-008 ID_VALID  output  1  decoded instruction available downstream.
REQ-009 ID_READY  input  1  downstream accepts the decoded instruction this cycle.
REQ-010 ID_PC  output  32  PC of head instruction.
REQ-011 ID_INSTR  output  25  head instruction bits [31:7]; feeds the immediate generator's INSTR input.
REQ-012 ID_IMM_TYPE  output  3  immediate class; feeds the immediate generator's IMM_TYPE input.
REQ-013 ID_RS1, ID_RS2, ID_RD  output  5 each  register indices: instr[19:15], [24:20], [11:7].
REQ-014 ID_ILLEGAL  output  1  head opcode is unrecognised.

Function
REQ-015 Transfer occurs on IF_VALID&IF_READY (accept) and on ID_VALID&ID_READY (issue); nothing else moves data.
REQ-016 Storage is a 2-entry FIFO (skid buffer); FSM states EMPTY, ONE, FULL.
REQ-017 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-018 ONE: accept without issue -> FULL; issue without accept -> EMPTY; both or neither -> ONE.
REQ-019 FULL: issue -> ONE; no issue -> FULL; no accept possible.
REQ-020 IF_READY is registered: 1 iff state != FULL; it never depends combinationally on ID_READY.
REQ-021 ID_VALID = (state != EMPTY); all ID_* outputs are driven from the head entry only.
REQ-022 Latency: instruction accepted in cycle N is presented on ID_* in cycle N+1 when the FIFO was EMPTY.
REQ-023 Order is strictly preserved; simultaneous accept and issue in ONE replaces the head with the new entry in one cycle.
REQ-024 ID_* outputs hold stable while ID_VALID&!ID_READY.
REQ-025 Decode is stored per entry at accept time (opcode = instr[6:0]): 0110011 -> R(000); 0010011, 0000011, 1100111, 0001111 -> I(001); 0100011 -> S(010); 1100011 -> B(011); 0110111, 0010111 -> U(100); 1101111 -> J(101); 1110011 with funct3 in {001,010,011,101,110,111} -> CSR(110); 1110011 with funct3 000 -> I(001).
REQ-026 Any other opcode, or funct3 100 under 1110011: ID_ILLEGAL=1, ID_IMM_TYPE=R(000); the entry still flows normally.
REQ-027 FLUSH=1: next state EMPTY regardless of accept/issue that cycle; a beat accepted in the FLUSH cycle is dropped; IF_READY=1 the following cycle.
REQ-028 FLUSH takes priority over all other events; issue in the FLUSH cycle is still counted as consumed downstream.
REQ-029 Code 111 is never produced on ID_IMM_TYPE.

Reset
REQ-030 RST_N low: state EMPTY immediately; IF_READY=1 (EMPTY), ID_VALID=0, ID_PC=0, ID_INSTR=0, ID_IMM_TYPE=000, ID_RS1/RS2/RD=0, ID_ILLEGAL=0.
REQ-031 Reset asserted mid-transfer discards all entries; no partial beat survives deassertion.
REQ-032 Reset deassertion is accepted synchronously to CLK; first accept is possible on the first edge after release.

Structure
REQ-033 Shared package holds immediate-type codes (R/I/S/B/U/J/CSR), RV32I opcode constants and FSM state encoding.
REQ-034 Combinational opcode-to-type decoder is sub-module imm_type_decoder (input instr[31:0]; outputs type[2:0], illegal), instantiated once on the accept path.

Verification
REQ-035 Reset then IF_INSTR=0x00500093 (addi), PC=0x100, ID_READY=1 -> next cycle ID_VALID=1, ID_IMM_TYPE=001, ID_RD=1, ID_RS1=0, ID_PC=0x100.
REQ-036 ID_READY=0, three back-to-back valid beats 0x00000463, 0x000000EF, 0x123450B7 -> IF_READY=0 after two; release yields B(011), J(101) in order, then U(100).
REQ-037 Continuous IF_VALID and ID_READY=1 for 10 beats -> one issue per cycle, state stays ONE, no bubbles.
REQ-038 FULL with FLUSH=1 and IF_VALID=1 -> next cycle ID_VALID=0, IF_READY=1, the flushed-cycle beat never appears.
REQ-039 IF_INSTR=0x30529073 (csrrw) -> ID_IMM_TYPE=110; IF_INSTR=0x0000007F -> ID_ILLEGAL=1, ID_IMM_TYPE=000.
REQ-040 RST_N low for one cycle while FULL -> ID_VALID=0 asynchronously, all ID_* zero, IF_READY=1.
